// File: rtl/regfile_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_pkg
// Purpose  : Shared widths, register-0 index and packed-port slicing helpers
//            for the multi-port register file.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_mp_pkg;

   localparam int DEF_DW   = 32;
   localparam int DEF_NREG = 32;
   localparam int DEF_NRD  = 4;
   localparam int DEF_NWR  = 2;

   // Hard-wired zero register
   localparam int REG0 = 0;

   // Base bit of field idx in a packed bus made of w-bit fields
   function automatic int unsigned lsb_of(input int unsigned idx, input int unsigned w);
      return idx * w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_if
// Purpose  : Read/write/scoreboard bus of the multi-port register file.
//            master drives requests, slave (the register file) answers.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_mp_if
   import regfile_mp_pkg::*;
#(
   parameter int DW   = DEF_DW,
   parameter int NREG = DEF_NREG,
   parameter int NRD  = DEF_NRD,
   parameter int NWR  = DEF_NWR
);
   localparam int AW = $clog2(NREG);

   logic [NRD*AW-1:0] raddr;
   logic [NRD*DW-1:0] rdata;
   logic [NRD-1:0]    rbusy;
   logic [NWR-1:0]    we;
   logic [NWR*AW-1:0] waddr;
   logic [NWR*DW-1:0] wdata;
   logic              alloc_v;
   logic [AW-1:0]     alloc_addr;
   logic              flush;
   logic [AW:0]       busy_cnt;

   modport master (
      output raddr, we, waddr, wdata, alloc_v, alloc_addr, flush,
      input  rdata, rbusy, busy_cnt
   );

   modport slave (
      input  raddr, we, waddr, wdata, alloc_v, alloc_addr, flush,
      output rdata, rbusy, busy_cnt
   );

endinterface
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : Register scoreboard: one busy bit per register with
//            write-clear / alloc-set / flush priority and a registered
//            popcount of busy registers.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb
   import regfile_mp_pkg::*;
#(
   parameter int NREG = DEF_NREG,
   parameter int NWR  = DEF_NWR,
   parameter int AW   = $clog2(NREG)
) (
   input  wire logic            clk,
   input  wire logic            rst,
   input  wire logic [NWR-1:0]    i_we,
   input  wire logic [NWR*AW-1:0] i_waddr,
   input  wire logic              i_alloc_v,
   input  wire logic [AW-1:0]     i_alloc_addr,
   input  wire logic              i_flush,
   output logic [NREG-1:0]        o_busy,
   output logic [AW:0]            o_busy_cnt
);
   localparam int CW = AW + 1;

   logic [NREG-1:0] r_busy;
   logic [CW-1:0]   r_busy_cnt;
   logic [NREG-1:0] w_busy_nxt;
   logic [CW-1:0]   w_cnt_nxt;

   // Next busy vector: writes clear, then flush wipes all or alloc sets (alloc beats write)
   always_comb begin
      w_busy_nxt = r_busy;
      for (int p = 0; p < NWR; p++) begin
         if (i_we[p]) begin
            w_busy_nxt[i_waddr[lsb_of(p, AW) +: AW]] = 1'b0;
         end
      end
      if (i_flush) begin
         w_busy_nxt = '0;
      end else if (i_alloc_v) begin
         w_busy_nxt[i_alloc_addr] = 1'b1;
      end
      w_busy_nxt[REG0] = 1'b0;
      w_cnt_nxt = '0;
      for (int r = 0; r < NREG; r++) begin
         w_cnt_nxt = w_cnt_nxt + CW'(w_busy_nxt[r]);
      end
   end

   // Busy bits and their count are registered together so the count tracks the bits
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy     <= '0;
         r_busy_cnt <= '0;
      end else begin
         r_busy     <= w_busy_nxt;
         r_busy_cnt <= w_cnt_nxt;
      end
   end

   assign o_busy     = r_busy;
   assign o_busy_cnt = r_busy_cnt;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Multi-read / multi-write register file with write-to-read
//            bypass, hard-wired zero register and a busy scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int DW   = DEF_DW,
   parameter int NREG = DEF_NREG,
   parameter int NRD  = DEF_NRD,
   parameter int NWR  = DEF_NWR
) (
   input  wire logic   clk,
   input  wire logic   rst,
   regfile_mp_if.slave bus
);
   localparam int AW = $clog2(NREG);

   logic [DW-1:0]     r_mem [NREG];
   logic [NREG-1:0]   w_busy;
   logic [AW:0]       w_busy_cnt;
   logic [NRD*DW-1:0] w_rdata;
   logic [NRD-1:0]    w_rbusy;

   // Array update; ports applied in ascending order so the highest index lands last
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) begin
            r_mem[r] <= '0;
         end
      end else begin
         for (int p = 0; p < NWR; p++) begin
            if (bus.we[p] && (bus.waddr[lsb_of(p, AW) +: AW] != AW'(REG0))) begin
               r_mem[bus.waddr[lsb_of(p, AW) +: AW]] <= bus.wdata[lsb_of(p, DW) +: DW];
            end
         end
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] w_ra;
      logic          w_hit;
      logic [DW-1:0] w_dat;

      assign w_ra = bus.raddr[lsb_of(i, AW) +: AW];

      // Bypass mux: the last (highest-index) hitting write port wins; r0 is always zero
      always_comb begin
         w_hit = 1'b0;
         w_dat = r_mem[w_ra];
         for (int p = 0; p < NWR; p++) begin
            if (bus.we[p] && (bus.waddr[lsb_of(p, AW) +: AW] == w_ra)) begin
               w_hit = 1'b1;
               w_dat = bus.wdata[lsb_of(p, DW) +: DW];
            end
         end
         if (w_ra == AW'(REG0)) begin
            w_hit = 1'b0;
            w_dat = '0;
         end
      end

      // A same-cycle write-back releases the consumer immediately
      assign w_rdata[i*DW +: DW] = w_dat;
      assign w_rbusy[i]          = w_busy[w_ra] & ~w_hit;
   end

   regfile_sb #(
      .NREG (NREG),
      .NWR  (NWR),
      .AW   (AW)
   ) u_sb (
      .clk          (clk),
      .rst          (rst),
      .i_we         (bus.we),
      .i_waddr      (bus.waddr),
      .i_alloc_v    (bus.alloc_v),
      .i_alloc_addr (bus.alloc_addr),
      .i_flush      (bus.flush),
      .o_busy       (w_busy),
      .o_busy_cnt   (w_busy_cnt)
   );

   assign bus.rdata    = w_rdata;
   assign bus.rbusy    = w_rbusy;
   assign bus.busy_cnt = w_busy_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Purpose  : Directed self-checking bench for regfile_mp (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;
   logic clk;
   logic rst;
   int   errors;
   int   checks;

   regfile_mp_if bus ();

   regfile_mp dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      bus.we         = '0;
      bus.waddr      = '0;
      bus.wdata      = '0;
      bus.alloc_v    = 1'b0;
      bus.alloc_addr = '0;
      bus.flush      = 1'b0;
      bus.raddr      = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      tick();
      tick();
      rst = 1'b0;
      bus.raddr = {5'd31, 5'd7, 5'd5, 5'd0};
      #1;
      checks++;
      if (bus.busy_cnt !== 6'd0) begin
         errors++;
         $display("FAIL reset_busy_cnt: got %0d expected 0", bus.busy_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bus.rdata[i*32 +: 32] !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata%0d: got %h expected 0", i, bus.rdata[i*32 +: 32]);
         end
         checks++;
         if (bus.rbusy[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset_rbusy%0d: got %b expected 0", i, bus.rbusy[i]);
         end
      end
   endtask

   task automatic test_write_read();
      idle();
      bus.we[0] = 1'b1;
      bus.waddr[4:0] = 5'd5;
      bus.wdata[31:0] = 32'hDEADBEEF;
      tick();
      idle();
      bus.raddr = {5'd5, 5'd0, 5'd0, 5'd5};
      #1;
      checks++;
      if (bus.rdata[31:0] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL wr_rd_r5_p0: got %h expected deadbeef", bus.rdata[31:0]);
      end
      checks++;
      if (bus.rdata[127:96] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL wr_rd_r5_p3: got %h expected deadbeef", bus.rdata[127:96]);
      end
      checks++;
      if (bus.rbusy[0] !== 1'b0) begin
         errors++;
         $display("FAIL wr_rd_rbusy: got %b expected 0", bus.rbusy[0]);
      end
   endtask

   task automatic test_conflict();
      idle();
      bus.we = 2'b11;
      bus.waddr = {5'd7, 5'd7};
      bus.wdata = {32'h22, 32'h11};
      bus.raddr[4:0] = 5'd7;
      #1;
      checks++;
      if (bus.rdata[31:0] !== 32'h22) begin
         errors++;
         $display("FAIL conflict_bypass: got %h expected 22", bus.rdata[31:0]);
      end
      tick();
      idle();
      bus.raddr[9:5] = 5'd7;
      #1;
      checks++;
      if (bus.rdata[63:32] !== 32'h22) begin
         errors++;
         $display("FAIL conflict_stored: got %h expected 22", bus.rdata[63:32]);
      end
   endtask

   task automatic test_bypass_ports();
      // Two ports to different registers, each read port sees its own writer
      idle();
      bus.we = 2'b11;
      bus.waddr = {5'd13, 5'd12};
      bus.wdata = {32'hB13, 32'hA12};
      bus.raddr = {5'd5, 5'd12, 5'd13, 5'd12};
      #1;
      checks++;
      if (bus.rdata !== {32'hDEADBEEF, 32'hA12, 32'hB13, 32'hA12}) begin
         errors++;
         $display("FAIL bypass_ports: got %h expected deadbeef00000a1200000b1300000a12", bus.rdata);
      end
      tick();
      idle();
   endtask

   task automatic test_scoreboard();
      idle();
      bus.alloc_v = 1'b1;
      bus.alloc_addr = 5'd3;
      tick();
      idle();
      bus.raddr[4:0] = 5'd3;
      #1;
      checks++;
      if (bus.rbusy[0] !== 1'b1) begin
         errors++;
         $display("FAIL sb_alloc_rbusy: got %b expected 1", bus.rbusy[0]);
      end
      checks++;
      if (bus.busy_cnt !== 6'd1) begin
         errors++;
         $display("FAIL sb_alloc_cnt: got %0d expected 1", bus.busy_cnt);
      end
      bus.we[0] = 1'b1;
      bus.waddr[4:0] = 5'd3;
      bus.wdata[31:0] = 32'h5;
      #1;
      checks++;
      if (bus.rbusy[0] !== 1'b0) begin
         errors++;
         $display("FAIL sb_wb_rbusy: got %b expected 0", bus.rbusy[0]);
      end
      checks++;
      if (bus.rdata[31:0] !== 32'h5) begin
         errors++;
         $display("FAIL sb_wb_rdata: got %h expected 5", bus.rdata[31:0]);
      end
      tick();
      idle();
      bus.raddr[4:0] = 5'd3;
      #1;
      checks++;
      if (bus.busy_cnt !== 6'd0) begin
         errors++;
         $display("FAIL sb_wb_cnt: got %0d expected 0", bus.busy_cnt);
      end
      checks++;
      if (bus.rbusy[0] !== 1'b0) begin
         errors++;
         $display("FAIL sb_wb_rbusy_after: got %b expected 0", bus.rbusy[0]);
      end
   endtask

   task automatic test_alloc_write_flush();
      idle();
      bus.we[0] = 1'b1;
      bus.waddr[4:0] = 5'd9;
      bus.wdata[31:0] = 32'hABCD;
      bus.alloc_v = 1'b1;
      bus.alloc_addr = 5'd9;
      tick();
      idle();
      bus.raddr[4:0] = 5'd9;
      #1;
      checks++;
      if (bus.rdata[31:0] !== 32'hABCD) begin
         errors++;
         $display("FAIL aw_data: got %h expected abcd", bus.rdata[31:0]);
      end
      checks++;
      if (bus.rbusy[0] !== 1'b1) begin
         errors++;
         $display("FAIL aw_busy: got %b expected 1", bus.rbusy[0]);
      end
      checks++;
      if (bus.busy_cnt !== 6'd1) begin
         errors++;
         $display("FAIL aw_cnt: got %0d expected 1", bus.busy_cnt);
      end
      // Flush drops the alloc but keeps the same-cycle write
      bus.flush = 1'b1;
      bus.alloc_v = 1'b1;
      bus.alloc_addr = 5'd4;
      bus.we[1] = 1'b1;
      bus.waddr[9:5] = 5'd10;
      bus.wdata[63:32] = 32'h77;
      tick();
      idle();
      bus.raddr = {5'd10, 5'd0, 5'd4, 5'd9};
      #1;
      checks++;
      if (bus.busy_cnt !== 6'd0) begin
         errors++;
         $display("FAIL flush_cnt: got %0d expected 0", bus.busy_cnt);
      end
      checks++;
      if (bus.rbusy !== 4'b0000) begin
         errors++;
         $display("FAIL flush_rbusy: got %b expected 0000", bus.rbusy);
      end
      checks++;
      if (bus.rdata[127:96] !== 32'h77) begin
         errors++;
         $display("FAIL flush_write: got %h expected 77", bus.rdata[127:96]);
      end
   endtask

   task automatic test_reg0();
      idle();
      bus.alloc_v = 1'b1;
      bus.alloc_addr = 5'd2;
      tick();
      idle();
      bus.we[1] = 1'b1;
      bus.waddr[9:5] = 5'd0;
      bus.wdata[63:32] = 32'hFFFFFFFF;
      bus.alloc_v = 1'b1;
      bus.alloc_addr = 5'd0;
      #1;
      checks++;
      if (bus.rdata[31:0] !== 32'h0 || bus.rbusy[0] !== 1'b0) begin
         errors++;
         $display("FAIL r0_inflight: got %h/%b expected 0/0", bus.rdata[31:0], bus.rbusy[0]);
      end
      tick();
      idle();
      #1;
      checks++;
      if (bus.rdata[31:0] !== 32'h0 || bus.rbusy[0] !== 1'b0) begin
         errors++;
         $display("FAIL r0_after: got %h/%b expected 0/0", bus.rdata[31:0], bus.rbusy[0]);
      end
      checks++;
      if (bus.busy_cnt !== 6'd1) begin
         errors++;
         $display("FAIL r0_cnt: got %0d expected 1", bus.busy_cnt);
      end
      bus.we[0] = 1'b1;
      bus.waddr[4:0] = 5'd2;
      bus.wdata[31:0] = 32'h2;
      tick();
      idle();
   endtask

   task automatic test_fill_reset();
      idle();
      for (int r = 1; r < 32; r++) begin
         bus.alloc_v = 1'b1;
         bus.alloc_addr = 5'(r);
         tick();
      end
      idle();
      bus.raddr = {5'd31, 5'd20, 5'd5, 5'd1};
      #1;
      checks++;
      if (bus.busy_cnt !== 6'd31) begin
         errors++;
         $display("FAIL fill_cnt: got %0d expected 31", bus.busy_cnt);
      end
      checks++;
      if (bus.rbusy !== 4'b1111) begin
         errors++;
         $display("FAIL fill_rbusy: got %b expected 1111", bus.rbusy);
      end
      // Reset with a write and alloc pending; the read still bypasses
      rst = 1'b1;
      bus.we[0] = 1'b1;
      bus.waddr[4:0] = 5'd20;
      bus.wdata[31:0] = 32'h55;
      bus.alloc_v = 1'b1;
      bus.alloc_addr = 5'd5;
      bus.raddr = {5'd0, 5'd0, 5'd0, 5'd20};
      #1;
      checks++;
      if (bus.rdata[31:0] !== 32'h55) begin
         errors++;
         $display("FAIL rst_bypass: got %h expected 55", bus.rdata[31:0]);
      end
      tick();
      rst = 1'b0;
      idle();
      bus.raddr = {5'd9, 5'd7, 5'd5, 5'd20};
      #1;
      checks++;
      if (bus.busy_cnt !== 6'd0) begin
         errors++;
         $display("FAIL rst_cnt: got %0d expected 0", bus.busy_cnt);
      end
      checks++;
      if (bus.rdata !== 128'h0) begin
         errors++;
         $display("FAIL rst_rdata: got %h expected 0", bus.rdata);
      end
      checks++;
      if (bus.rbusy !== 4'b0000) begin
         errors++;
         $display("FAIL rst_rbusy: got %b expected 0000", bus.rbusy);
      end
      bus.we[1] = 1'b1;
      bus.waddr[9:5] = 5'd5;
      bus.wdata[63:32] = 32'h1234;
      tick();
      idle();
      bus.raddr[4:0] = 5'd5;
      #1;
      checks++;
      if (bus.rdata[31:0] !== 32'h1234 || bus.rbusy[0] !== 1'b0) begin
         errors++;
         $display("FAIL post_rst_write: got %h/%b expected 1234/0", bus.rdata[31:0], bus.rbusy[0]);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst    = 1'b1;
      idle();
      test_reset();
      test_write_read();
      test_conflict();
      test_bypass_ports();
      test_scoreboard();
      test_alloc_write_flush();
      test_reg0();
      test_fill_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DW, default 32: data width of each register.
REQ-002 Parameter NREG, default 32: register count, power of two, at least 2; AW = clog2(NREG).
REQ-003 Parameter NRD, default 4: number of read ports.
REQ-004 Parameter NWR, default 2: number of write ports; a higher index has higher priority.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 raddr  input  NRD*AW  read addresses; port i is bits [i*AW +: AW].
REQ-008 rdata  output  NRD*DW  read data; port i is bits [i*DW +: DW].
REQ-009 rbusy  output  NRD  scoreboard busy flag for each read address.
REQ-010 we  input  NWR  write enable for each write port.
REQ-011 waddr  input  NWR*AW  write addresses.
REQ-012 wdata  input  NWR*DW  write data.
REQ-013 alloc_v  input  1  marks alloc_addr as having a pending producer.
REQ-014 alloc_addr  input  AW  destination register to mark busy.
REQ-015 flush  input  1  clears every busy bit (pipeline squash).
REQ-016 busy_cnt  output  AW+1  registered count of busy registers.

Function
REQ-017 Reads SHALL be combinational, with zero-cycle latency.
REQ-018 Register 0 SHALL always read 0, with rbusy 0.
- Writes, allocs and bypass to register 0 SHALL be ignored.
REQ-019 Read-port bypass: if any write port hits raddr[i] this cycle, rdata[i] SHALL be the wdata of the highest-index hitting port; otherwise it SHALL be the array contents.
REQ-020 Write conflict: when several enabled ports share a waddr, only the highest-index port's data SHALL be stored at the next edge.
REQ-021 Scoreboard: one busy bit per register.
- An enabled write to register r SHALL clear busy[r] at the next edge.
- An alloc_v to r SHALL set busy[r] at the next edge.
REQ-022 Alloc and write to the same register in the same cycle: the alloc SHALL win, leaving busy set.
REQ-023 rbusy[i] = busy[raddr[i]] AND NOT (any write port hits raddr[i] this cycle).
- This lets a consumer issue in the same cycle its producer writes back.
REQ-024 flush SHALL clear all busy bits at the next edge.
- Any alloc_v in the same cycle SHALL be dropped.
- Writes in the same cycle SHALL still update the array.
REQ-025 busy_cnt SHALL equal the popcount of the busy bits and change one cycle after the causing event.
- It SHALL never exceed NREG-1.
REQ-026 There SHALL be no back-pressure: every write and alloc is accepted in its cycle.

Reset
REQ-027 When rst=1 at an edge, all registers, all busy bits and busy_cnt SHALL become 0.
- Reset SHALL override we, alloc_v and flush in that cycle.
REQ-028 While rst=1, reads SHALL still be combinational over the current array plus bypass.
- Data written during reset SHALL NOT be retained.
REQ-029 Reset asserted between an alloc and its write-back SHALL leave the register not busy.
- A later write to that register SHALL be stored normally.

Structure
REQ-030 The shared package SHALL hold the default widths, the register-0 index constant, and the packed-port slicing helpers.
REQ-031 Sub-module regfile_sb SHALL hold the busy bits, the set/clear/flush priority logic and busy_cnt.
- regfile_mp SHALL instantiate it once and keep the data array and bypass muxes.

Verification
REQ-032 Reset, then write 0xDEADBEEF to r5 via port0 -> the next cycle, raddr=5 reads 0xDEADBEEF; rbusy=0.
REQ-033 Same cycle: port0 writes r7=0x11 and port1 writes r7=0x22, with raddr0=7 -> in-cycle rdata0=0x22; after the edge r7 reads 0x22.
REQ-034 alloc r3 -> next cycle rbusy=1, busy_cnt=1; then write r3=0x5 -> in-cycle rbusy=0 and rdata=0x5; after the edge busy_cnt=0.
REQ-035 Write r9 together with alloc r9 in one cycle -> r9 holds the written data and busy[r9] stays 1; flush together with alloc r4 -> busy_cnt=0 and r4 not busy.
REQ-036 Write 0xFFFFFFFF to r0 and alloc r0 -> r0 reads 0, rbusy=0, busy_cnt unchanged.
REQ-037 Allocate r1..r31, then assert rst -> busy_cnt=31 before reset and 0 after; all reads return 0.
